// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer with a small instruction queue toward decode.
// Optional macro FETCH_MISALIGN_CHK_EN adds a sticky misaligned-redirect error output.
module pc_fetch_unit #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int               QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic            misalign_err
`endif
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_DROP
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [XLEN-1:0] instr_mem_q [QDEPTH];
   logic [XLEN-1:0] instr_mem_d [QDEPTH];
   logic [XLEN-1:0] pc_mem_q    [QDEPTH];
   logic [XLEN-1:0] pc_mem_d    [QDEPTH];

   logic redir_take;
   logic credit;
   logic req_valid;
   logic req_fire;
   logic push;
   logic pop;
   logic queue_valid;

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;
   // Misaligned targets are reported and otherwise ignored, leaving fetch undisturbed.
   assign redir_take = redirect_valid && (redirect_pc[1:0] == 2'b00);
   assign misalign_err = misalign_q;
`else
   logic unused_redirect_lsbs;
   assign redir_take = redirect_valid;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

   // Outstanding requests count against the queue so a response always has a slot.
   assign credit      = (count_q < CW'(QDEPTH));
   assign req_valid   = !rst && (state_q == ST_REQ) && credit;
   assign req_fire    = req_valid && imem_req_ready;
   assign queue_valid = !rst && (count_q != '0);
   assign push        = (state_q == ST_WAIT) && imem_rsp_valid && !redir_take;
   assign pop         = queue_valid && out_ready && !redir_take;

   assign imem_req_valid = req_valid;
   assign imem_req_addr  = rst ? RESET_PC : pc_q;
   assign out_valid      = queue_valid;
   assign out_instr      = instr_mem_q[rd_ptr_q];
   assign out_pc         = pc_mem_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_d  = misalign_q;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         misalign_d = 1'b1;
      end
`endif

      if (redir_take) begin
         // A request still in flight must be drained in DROP before fetching again.
         pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         if (state_q == ST_REQ) begin
            state_d = req_fire ? ST_DROP : ST_REQ;
         end else begin
            state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
         end
      end else begin
         case (state_q)
            ST_REQ: begin
               if (req_fire) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + XLEN'(4);
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  state_d = ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem_rsp_valid) begin
                  state_d = ST_REQ;
               end
            end
            default: state_d = ST_REQ;
         endcase

         if (push) begin
            instr_mem_d[wr_ptr_q] = imem_rsp_data;
            pc_mem_d[wr_ptr_q]    = req_pc_q;
            wr_ptr_d              = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         instr_mem_q <= '{default: '0};
         pc_mem_q    <= '{default: '0};
`ifdef FETCH_MISALIGN_CHK_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
`ifdef FETCH_MISALIGN_CHK_EN
         misalign_q  <= misalign_d;
`endif
      end
   end

   // The credit rule should make overflow unreachable; catch it if that ever breaks.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && (count_q == CW'(QDEPTH))))
            else $error("pc_fetch_unit: push into full instruction queue");
      end
   end

endmodule
